// File: rtl/if_fetch_ctrl.sv
// IF-stage PC register and instruction fetch initiator: one outstanding SRAM read
// per PC, holds the fetched word for ID, and discards responses for superseded PCs.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPC,
  input  logic        PC_Flush,
  input  logic        PCWr,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] PC,
  output logic        IF_valid,
  output logic [31:0] IF_inst,
  output logic        IF_AdEL
);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_CANCEL = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_adel;

  logic        w_misaligned;
  logic        w_req;
  logic        w_accept;

  // Request is a pure decode of registered state so a freshly loaded PC is
  // presented on the bus in the same cycle it appears.
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_req        = (r_state == S_REQ) && !w_misaligned;
  assign w_accept     = w_req && inst_sram_addr_ok;

  assign inst_sram_req  = w_req && !rst;
  assign inst_sram_addr = rst ? 32'h0 : r_pc;
  assign PC             = r_pc;
  assign IF_valid       = (r_state == S_HOLD) && !rst;
  assign IF_inst        = rst ? 32'h0 : r_inst;
  assign IF_AdEL        = r_adel && (r_state == S_HOLD) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
      r_adel  <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (PC_Flush) begin
            r_pc    <= NPC;
            // An accepted stale request still owes us one response.
            r_state <= w_accept ? S_CANCEL : S_REQ;
          end else if (w_misaligned) begin
            r_state <= S_HOLD;
            r_adel  <= 1'b1;
            r_inst  <= 32'h0;
          end else if (w_accept) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (PC_Flush) begin
            r_pc    <= NPC;
            r_state <= inst_sram_data_ok ? S_REQ : S_CANCEL;
          end else if (inst_sram_data_ok) begin
            r_inst  <= inst_sram_rdata;
            r_adel  <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (PC_Flush || PCWr) begin
            r_pc    <= NPC;
            r_adel  <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_CANCEL: begin
          if (PC_Flush) begin
            r_pc <= NPC;
          end
          if (inst_sram_data_ok) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch unit.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] Z = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] NPC = 32'h0;
  logic        PC_Flush = 1'b0;
  logic        PCWr = 1'b0;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic [31:0] PC;
  logic        IF_valid;
  logic [31:0] IF_inst;
  logic        IF_AdEL;

  int checks = 0;
  int failures = 0;

  // Model: the current PC, whether its read is in flight, whether its result
  // (instruction or address error) is held for ID, and stale responses owed.
  logic [31:0] m_pc = RESET_PC;
  logic        m_issued = 1'b0;
  logic        m_have = 1'b0;
  logic        m_adel = 1'b0;
  logic [31:0] m_inst = 32'h0;
  int          m_stale = 0;
  logic        m_acc = 1'b0;

  if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .NPC              (NPC),
    .PC_Flush         (PC_Flush),
    .PCWr             (PCWr),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata),
    .PC               (PC),
    .IF_valid         (IF_valid),
    .IF_inst          (IF_inst),
    .IF_AdEL          (IF_AdEL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input logic t_rst, input logic t_flush, input logic t_pcwr,
                      input logic [31:0] t_npc, input logic t_aok, input logic t_dok,
                      input logic [31:0] t_rdata);
    logic exp_req;
    logic old_have;
    logic idle;
    int   s;
    @(negedge clk);
    rst = t_rst; PC_Flush = t_flush; PCWr = t_pcwr; NPC = t_npc;
    inst_sram_addr_ok = t_aok; inst_sram_data_ok = t_dok; inst_sram_rdata = t_rdata;
    #1;
    idle    = (m_stale == 0) && !m_issued && !m_have;
    exp_req = !t_rst && idle && (m_pc[1:0] == 2'b00);
    if (t_rst) begin
      chk("rst_req", {31'h0, inst_sram_req}, 32'h0);
      chk("rst_valid", {31'h0, IF_valid}, 32'h0);
      chk("rst_inst", IF_inst, 32'h0);
      chk("rst_adel", {31'h0, IF_AdEL}, 32'h0);
    end else begin
      chk("req", {31'h0, inst_sram_req}, {31'h0, exp_req});
      if (exp_req) chk("addr", inst_sram_addr, m_pc);
      chk("pc", PC, m_pc);
      chk("valid", {31'h0, IF_valid}, {31'h0, m_have});
      chk("adel", {31'h0, IF_AdEL}, {31'h0, m_have && m_adel});
      if (m_have) chk("inst", IF_inst, m_inst);
    end
    m_acc = exp_req && t_aok;
    if (t_rst) begin
      m_pc = RESET_PC; m_issued = 0; m_have = 0; m_adel = 0; m_stale = 0;
    end else if (t_flush) begin
      s = m_stale;
      if (m_stale > 0) begin
        if (t_dok) s--;
      end else if (m_issued && !t_dok) begin
        s++;
      end
      if (m_acc) s++;
      m_stale = s; m_pc = t_npc; m_issued = 0; m_have = 0; m_adel = 0;
    end else begin
      old_have = m_have;
      if (t_dok) begin
        if (m_stale > 0) m_stale--;
        else if (m_issued) begin
          m_inst = t_rdata; m_have = 1; m_issued = 0; m_adel = 0;
        end
      end
      if (m_acc) m_issued = 1;
      if (idle && m_pc[1:0] != 2'b00) begin
        m_have = 1; m_adel = 1; m_inst = 0;
      end else if (old_have && t_pcwr) begin
        $display("ID takes pc=%h inst=%h adel=%0d next=%h", m_pc, m_inst, m_adel, t_npc);
        m_pc = t_npc; m_have = 0; m_adel = 0;
      end
    end
  endtask

  initial begin
    logic        r_b, f_b, w_b, a_b, d_b;
    logic [31:0] n_b;
    logic        resp_pending;
    int          resp_wait;
    int          r;

    step(1, 0, 0, Z, 0, 0, Z);
    step(1, 0, 0, Z, 0, 0, Z);

    // 1: zero-wait fetch from boot vector, then sequential advance
    step(0, 0, 0, Z, 1, 0, Z);
    chk("t1_req", {31'h0, inst_sram_req}, 32'h1);
    chk("t1_addr", inst_sram_addr, 32'hBFC0_0000);
    step(0, 0, 0, Z, 0, 1, 32'h2408_0001);
    chk("t1_novalid", {31'h0, IF_valid}, 32'h0);
    step(0, 0, 1, 32'hBFC0_0004, 0, 0, Z);
    chk("t1_valid", {31'h0, IF_valid}, 32'h1);
    chk("t1_inst", IF_inst, 32'h2408_0001);
    step(0, 0, 0, Z, 0, 0, Z);
    chk("t1_addr2", inst_sram_addr, 32'hBFC0_0004);

    // 2: addr_ok held off for three cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, Z, 0, 0, Z);
      chk("t2_req", {31'h0, inst_sram_req}, 32'h1);
      chk("t2_addr", inst_sram_addr, 32'hBFC0_0004);
      chk("t2_novalid", {31'h0, IF_valid}, 32'h0);
    end
    step(0, 0, 0, Z, 1, 0, Z);
    step(0, 0, 0, Z, 0, 1, 32'h0000_0000);
    step(0, 0, 1, 32'hBFC0_0008, 0, 0, Z);

    // 3: redirect while waiting, stale response two cycles later
    step(0, 0, 0, Z, 1, 0, Z);
    step(0, 1, 0, 32'hBFC0_0380, 0, 0, Z);
    step(0, 0, 0, Z, 0, 0, Z);
    chk("t3_noreq", {31'h0, inst_sram_req}, 32'h0);
    step(0, 0, 0, Z, 0, 1, 32'hDEAD_BEEF);
    chk("t3_novalid", {31'h0, IF_valid}, 32'h0);
    step(0, 0, 0, Z, 1, 0, Z);
    chk("t3_addr", inst_sram_addr, 32'hBFC0_0380);
    step(0, 0, 0, Z, 0, 1, 32'h3C1A_0001);
    step(0, 0, 1, 32'hBFC0_0384, 0, 0, Z);
    chk("t3_inst", IF_inst, 32'h3C1A_0001);

    // 4: redirect in the same cycle the stale request is accepted
    step(0, 1, 0, 32'hBFC0_0500, 1, 0, Z);
    step(0, 0, 0, Z, 0, 1, 32'hBAD0_BAD0);
    chk("t4_noreq", {31'h0, inst_sram_req}, 32'h0);
    chk("t4_novalid", {31'h0, IF_valid}, 32'h0);
    step(0, 0, 0, Z, 1, 0, Z);
    chk("t4_addr", inst_sram_addr, 32'hBFC0_0500);
    step(0, 0, 0, Z, 0, 1, 32'h1111_2222);
    step(0, 0, 0, Z, 0, 0, Z);
    chk("t4_inst", IF_inst, 32'h1111_2222);

    // 5: redirect to a misaligned PC
    step(0, 1, 0, 32'hBFC0_0102, 0, 0, Z);
    step(0, 0, 0, Z, 1, 0, Z);
    chk("t5_noreq", {31'h0, inst_sram_req}, 32'h0);
    chk("t5_pc", PC, 32'hBFC0_0102);
    step(0, 0, 0, Z, 1, 0, Z);
    chk("t5_valid", {31'h0, IF_valid}, 32'h1);
    chk("t5_adel", {31'h0, IF_AdEL}, 32'h1);
    chk("t5_inst", IF_inst, 32'h0);
    step(0, 0, 1, 32'hBFC0_0600, 0, 0, Z);
    chk("t5_adel_held", {31'h0, IF_AdEL}, 32'h1);
    step(0, 0, 0, Z, 0, 0, Z);
    chk("t5_adel_clr", {31'h0, IF_AdEL}, 32'h0);
    chk("t5_addr", inst_sram_addr, 32'hBFC0_0600);

    // 6: long hold, then PC_Flush and PCWr together
    step(0, 0, 0, Z, 1, 0, Z);
    step(0, 0, 0, Z, 0, 1, 32'hABCD_1234);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, Z, 0, 0, Z);
      chk("t6_stable", IF_inst, 32'hABCD_1234);
    end
    step(0, 1, 1, 32'hBFC0_0700, 0, 0, Z);
    step(0, 0, 0, 32'hBFC0_0999, 0, 0, Z);
    chk("t6_novalid", {31'h0, IF_valid}, 32'h0);
    chk("t6_pc", PC, 32'hBFC0_0700);
    step(0, 0, 0, 32'hBFC0_0999, 0, 0, Z);
    chk("t6_pc_once", PC, 32'hBFC0_0700);

    // Randomized traffic against a one-outstanding SRAM with variable latency
    resp_pending = 0;
    resp_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      r_b = (c < 2) || ($urandom_range(0, 199) == 0);
      f_b = ($urandom_range(0, 9) == 0);
      w_b = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 19);
      if (r == 0)     n_b = m_pc + 32'd2;
      else if (r < 4) n_b = $urandom & 32'hFFFF_FFFC;
      else            n_b = m_pc + 32'd4;
      a_b = ($urandom_range(0, 2) != 0);
      if (resp_pending && resp_wait == 0) begin
        d_b = 1;
        resp_pending = 0;
      end else if (resp_pending) begin
        d_b = 0;
        resp_wait--;
      end else begin
        d_b = ($urandom_range(0, 19) == 0);
      end
      step(r_b, f_b, w_b, n_b, a_b, d_b, $urandom);
      if (r_b) resp_pending = 0;
      else if (m_acc) begin
        resp_pending = 1;
        resp_wait = $urandom_range(0, 3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
